// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the IF/ID payload layout used by pipe_stage_reg.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_payload_t;

    // Reset payload: pc of zero carrying a NOP instruction
    localparam logic [63:0] RST_DATA_DEFAULT = {32'h0000_0000, NOP_INSTR};

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with a one-cycle latency and a registered output.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready comes straight from a flop.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RST_DATA = DATA_W'(RST_DATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              r_outValid;
    logic [DATA_W-1:0] r_outData;
    logic              w_accept;
    logic              w_emit;

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign w_accept  = in_valid && in_ready;
    assign w_emit    = r_outValid && out_ready;

`ifdef PIPE_STAGE_SKID_EN

    logic              r_skidValid;
    logic [DATA_W-1:0] r_skidData;
    logic              r_inReady;

    assign in_ready = r_inReady;

    // The main entry refills from the skid first so order is preserved; an accept
    // that arrives while the main entry is stalled parks in the skid entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_outValid  <= 1'b0;
            r_outData   <= RST_DATA;
            r_skidValid <= 1'b0;
            r_skidData  <= RST_DATA;
            r_inReady   <= 1'b1;
        end else if (!r_outValid || w_emit) begin
            if (r_skidValid) begin
                r_outValid  <= 1'b1;
                r_outData   <= r_skidData;
                r_skidValid <= 1'b0;
                r_inReady   <= 1'b1;
            end else if (w_accept) begin
                r_outValid <= 1'b1;
                r_outData  <= in_data;
            end else begin
                r_outValid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skidValid <= 1'b1;
            r_skidData  <= in_data;
            r_inReady   <= 1'b0;
        end
    end

`else

    assign in_ready = out_ready || !r_outValid;

    // Single entry: an accept always overwrites, covering the emit-and-refill case
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_outValid <= 1'b0;
            r_outData  <= RST_DATA;
        end else if (w_accept) begin
            r_outValid <= 1'b1;
            r_outData  <= in_data;
        end else if (w_emit) begin
            r_outValid <= 1'b0;
        end
    end

`endif

endmodule
